uart_alu_ctrl: RTL

UART_ALU_CTRL -- requirements
Module: uart_alu_ctrl

---
 rtl/uart_alu_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/uart_alu_ctrl.sv
// Byte-oriented ALU sequencer: pops A, B, OP from an RX FIFO, computes, pushes the result to a TX FIFO.
// Latency: rd strobes are combinational with capture on the same edge; wr asserts two cycles after the OP-capturing rd cycle.
// Backpressure: rx_empty holds the FSM in the GET states, tx_full holds it in SEND with w_data stable.
module uart_alu_ctrl #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] r_data,
  input  logic         rx_empty,
  output logic         rd,
  output logic [N-1:0] w_data,
  input  logic         tx_full,
  output logic         wr,
  output logic         op_err,
  output logic         busy
);

  // Supported opcodes, widened or truncated to the operand width.
  localparam logic [N-1:0] OP_ADD = N'(8'h20);
  localparam logic [N-1:0] OP_SUB = N'(8'h22);
  localparam logic [N-1:0] OP_AND = N'(8'h24);
  localparam logic [N-1:0] OP_OR  = N'(8'h25);
  localparam logic [N-1:0] OP_XOR = N'(8'h26);
  localparam logic [N-1:0] OP_NOR = N'(8'h27);
  localparam logic [N-1:0] OP_SRL = N'(8'h02);
  localparam logic [N-1:0] OP_SRA = N'(8'h03);

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    CALC   = 3'd3,
    SEND   = 3'd4
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  logic [N-1:0] r_op;
  logic [N-1:0] r_wdata;

  logic         w_rd;
  logic         w_wr;
  logic         w_err;
  logic         w_busy;
  logic [N-1:0] w_result;
  logic         w_bad_op;
  logic [2:0]   w_shamt;

  // Only the low three bits of B select the shift distance.
  assign w_shamt = r_b[2:0];

  // State register; reset drops any partially collected operand set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= GET_A;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and strobe decode; pops and pushes are single-cycle and gated by FIFO flags.
  always_comb begin
    w_next = r_state;
    w_rd   = 1'b0;
    w_wr   = 1'b0;
    w_err  = 1'b0;
    w_busy = 1'b1;
    case (r_state)
      GET_A: begin
        w_busy = 1'b0;
        if (!rx_empty) begin
          w_rd   = 1'b1;
          w_next = GET_B;
        end
      end
      GET_B: begin
        if (!rx_empty) begin
          w_rd   = 1'b1;
          w_next = GET_OP;
        end
      end
      GET_OP: begin
        if (!rx_empty) begin
          w_rd   = 1'b1;
          w_next = CALC;
        end
      end
      CALC: begin
        w_err  = w_bad_op;
        w_next = SEND;
      end
      SEND: begin
        if (!tx_full) begin
          w_wr   = 1'b1;
          w_next = GET_A;
        end
      end
      default: begin
        w_busy = 1'b0;
        w_next = GET_A;
      end
    endcase
  end

  // Operand capture on the same edge that completes each pop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_a  <= '0;
      r_b  <= '0;
      r_op <= '0;
    end else begin
      if (w_rd && (r_state == GET_A)) begin
        r_a <= r_data;
      end
      if (w_rd && (r_state == GET_B)) begin
        r_b <= r_data;
      end
      if (w_rd && (r_state == GET_OP)) begin
        r_op <= r_data;
      end
    end
  end

  // ALU datapath; all results wrap modulo 2^N, unknown opcodes yield zero.
  always_comb begin
    w_result = '0;
    w_bad_op = 1'b0;
    case (r_op)
      OP_ADD:  w_result = r_a + r_b;
      OP_SUB:  w_result = r_a - r_b;
      OP_AND:  w_result = r_a & r_b;
      OP_OR:   w_result = r_a | r_b;
      OP_XOR:  w_result = r_a ^ r_b;
      OP_NOR:  w_result = ~(r_a | r_b);
      OP_SRL:  w_result = r_a >> w_shamt;
      OP_SRA:  w_result = $signed(r_a) >>> w_shamt;
      default: begin
        w_result = '0;
        w_bad_op = 1'b1;
      end
    endcase
  end

  // Result register loads only on the CALC->SEND edge so w_data is stable through any TX stall.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wdata <= '0;
    end else if (r_state == CALC) begin
      r_wdata <= w_result;
    end
  end

  // Strobes are forced low while reset is asserted, independent of the clock.
  assign rd     = w_rd   & reset;
  assign wr     = w_wr   & reset;
  assign op_err = w_err  & reset;
  assign busy   = w_busy & reset;
  assign w_data = r_wdata;

endmodule
